// File: rtl/uart_pkg.sv
// Shared types for the UART receive-side controller: handshake states,
// FIFO entry layout and the parity-error counter ceiling.
package uart_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic [7:0] ERRCNT_MAX = 8'd255;

endpackage

// File: rtl/rx_ctrl_sync_fifo.sv
// First-word-fall-through FIFO: head is read straight from storage, and a
// push into a full FIFO is accepted when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic                       push_ok,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_LEVEL) || do_pop);
  assign push_ok = do_push;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_ctrl.sv
// Receiver-side controller: acknowledges each received byte, queues it with
// its parity flag, and tracks overrun and parity-error status.
module rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit DROP_PERR = 1'b0
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  input  logic                   Receive,
  input  logic [7:0]             Dout,
  input  logic                   parityErr,
  output logic                   Received,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_perr,
  input  logic                   out_ready,
  output logic                   Overrun,
  output logic [7:0]             ErrCount,
  output logic [$clog2(DEPTH):0] Level,
  input  logic                   ClrStatus,
  output logic [1:0]             dbg_state
);

  rx_state_t state;
  rx_state_t next_state;
  rx_entry_t wr_entry;
  rx_entry_t head;
  logic      capture;
  logic      push_req;
  logic      push_ok;
  logic      overrun_evt;
  logic      perr_evt;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= WAIT;
    else          state <= next_state;
  end

  // RELEASE waits for Receive to drop so a held request is not captured twice.
  always_comb begin
    next_state = state;
    case (state)
      WAIT:    if (Receive) next_state = ACK;
      ACK:     next_state = RELEASE;
      RELEASE: if (!Receive) next_state = WAIT;
      default: next_state = WAIT;
    endcase
  end

  assign Received  = (state == ACK);
  assign dbg_state = state;

  assign capture     = (state == WAIT) && Receive;
  assign perr_evt    = capture && parityErr;
  assign push_req    = capture && !(DROP_PERR && parityErr);
  assign overrun_evt = push_req && !push_ok;
  assign wr_entry    = '{perr: parityErr, data: Dout};

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rx_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (Reset_n),
    .push    (push_req),
    .din     (wr_entry),
    .pop     (out_ready),
    .push_ok (push_ok),
    .head    (head),
    .level   (Level)
  );

  assign out_valid = (Level != '0);
  assign out_data  = head.data;
  assign out_perr  = head.perr;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Overrun  <= 1'b0;
      ErrCount <= '0;
    end else if (ClrStatus) begin
      Overrun  <= 1'b0;
      ErrCount <= '0;
    end else begin
      if (overrun_evt) Overrun <= 1'b1;
      if (perr_evt && (ErrCount != ERRCNT_MAX)) ErrCount <= ErrCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed bench for rx_ctrl: one instance keeps parity-error bytes, a
// second instance on the same stimulus drops them.
module tb_rx_ctrl;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Receive;
  logic [7:0] Dout;
  logic       parityErr;
  logic       out_ready;
  logic       ClrStatus;

  logic       Received, out_valid, out_perr, Overrun;
  logic [7:0] out_data, ErrCount;
  logic [3:0] Level;
  logic [1:0] dbg_state;

  logic       Received_d, out_valid_d, out_perr_d, Overrun_d;
  logic [7:0] out_data_d, ErrCount_d;
  logic [3:0] Level_d;
  logic [1:0] dbg_state_d;

  int errors = 0;
  int checks = 0;
  int pulses_d = 0;

  always #5 clk = ~clk;

  rx_ctrl #(.DEPTH(8), .DROP_PERR(1'b0)) dut (
    .clk(clk), .Reset_n(Reset_n), .Receive(Receive), .Dout(Dout),
    .parityErr(parityErr), .Received(Received), .out_valid(out_valid),
    .out_data(out_data), .out_perr(out_perr), .out_ready(out_ready),
    .Overrun(Overrun), .ErrCount(ErrCount), .Level(Level),
    .ClrStatus(ClrStatus), .dbg_state(dbg_state)
  );

  rx_ctrl #(.DEPTH(8), .DROP_PERR(1'b1)) dut_d (
    .clk(clk), .Reset_n(Reset_n), .Receive(Receive), .Dout(Dout),
    .parityErr(parityErr), .Received(Received_d), .out_valid(out_valid_d),
    .out_data(out_data_d), .out_perr(out_perr_d), .out_ready(out_ready),
    .Overrun(Overrun_d), .ErrCount(ErrCount_d), .Level(Level_d),
    .ClrStatus(ClrStatus), .dbg_state(dbg_state_d)
  );

  task automatic do_reset();
    Reset_n   = 1'b0;
    Receive   = 1'b0;
    Dout      = 8'h00;
    parityErr = 1'b0;
    out_ready = 1'b0;
    ClrStatus = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Full receiver handshake: raise Receive, wait for Received, drop Receive,
  // and leave the FSM back in WAIT. Counts Received cycles of the drop instance.
  task automatic send_byte(input logic [7:0] d, input logic p);
    int n;
    Dout      = d;
    parityErr = p;
    Receive   = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (Received_d) pulses_d++;
    end while (!Received && n < 8);
    checks++;
    if (!Received) begin
      errors++;
      $display("FAIL send_timeout: Received=%0b after %0d cycles, required 1", Received, n);
    end
    Receive = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (Received_d) pulses_d++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Receive = 1'b0;
    out_ready = 1'b0;
    ClrStatus = 1'b0;
    Dout = 8'h00;
    parityErr = 1'b0;
    #12;
    checks++; if (Received !== 1'b0) begin errors++; $display("FAIL reset_received: got %0b want 0", Received); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b want 0", out_perr); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b want 0", Overrun); end
    checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL reset_errcount: got %0d want 0", ErrCount); end
    checks++; if (Level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", Level); end
    checks++; if (dbg_state !== WAIT) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, WAIT); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    Dout = 8'hA5; parityErr = 1'b0; Receive = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %0b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (Received !== 1'b1) begin errors++; $display("FAIL single_ack: got %0b want 1", Received); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", out_data); end
    checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL single_perr: got %0b want 0", out_perr); end
    checks++; if (Level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", Level); end
    @(posedge clk); #1;
    checks++; if (Received !== 1'b0) begin errors++; $display("FAIL single_ack_width: got %0b want 0", Received); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (dbg_state !== RELEASE) begin errors++; $display("FAIL hold_state: got %0d want %0d", dbg_state, RELEASE); end
    checks++; if (Level !== 4'd1) begin errors++; $display("FAIL hold_level: got %0d want 1", Level); end
    Receive = 1'b0;
    @(posedge clk); #1;
    checks++; if (dbg_state !== WAIT) begin errors++; $display("FAIL hold_exit: got %0d want %0d", dbg_state, WAIT); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || Level !== 4'd0) begin
      errors++; $display("FAIL single_pop: valid=%0b level=%0d want 0/0", out_valid, Level);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b0);
    checks++; if (Level !== 4'd8) begin errors++; $display("FAIL ovr_level: got %0d want 8", Level); end
    checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b want 1", Overrun); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        errors++; $display("FAIL ovr_pop%0d: valid=%0b data=%h want 1/%h", i, out_valid, out_data, 8'(i));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (Level !== 4'd0) begin errors++; $display("FAIL ovr_lost: level=%0d want 0", Level); end
    checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0b want 1", Overrun); end
    ClrStatus = 1'b1;
    @(posedge clk); #1;
    ClrStatus = 1'b0;
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %0b want 0", Overrun); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q[$];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i), 1'b0);
      if (i > 0) exp_q.push_back(8'h10 + 8'(i));
    end
    exp_q.push_back(8'h55);
    checks++; if (Level !== 4'd8 || Overrun !== 1'b0) begin
      errors++; $display("FAIL fp_fill: level=%0d overrun=%0b want 8/0", Level, Overrun);
    end
    Dout = 8'h55; parityErr = 1'b0; Receive = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (Level !== 4'd8) begin errors++; $display("FAIL fp_level: got %0d want 8", Level); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL fp_overrun: got %0b want 0", Overrun); end
    Receive = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        errors++; $display("FAIL fp_order: valid=%0b data=%h want 1/%h", out_valid, out_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (Level !== 4'd0) begin errors++; $display("FAIL fp_drain: level=%0d want 0", Level); end
  endtask

  task automatic test_perr();
    do_reset();
    pulses_d = 0;
    for (int i = 0; i < 3; i++) send_byte(8'h31 + 8'(i), 1'b1);
    checks++; if (ErrCount !== 8'd3) begin errors++; $display("FAIL perr_count: got %0d want 3", ErrCount); end
    checks++; if (Level !== 4'd3) begin errors++; $display("FAIL perr_level: got %0d want 3", Level); end
    checks++; if (ErrCount_d !== 8'd3) begin errors++; $display("FAIL perr_drop_count: got %0d want 3", ErrCount_d); end
    checks++; if (Level_d !== 4'd0) begin errors++; $display("FAIL perr_drop_level: got %0d want 0", Level_d); end
    checks++; if (pulses_d !== 3) begin errors++; $display("FAIL perr_drop_acks: got %0d want 3", pulses_d); end
    checks++; if (Overrun_d !== 1'b0) begin errors++; $display("FAIL perr_drop_ovr: got %0b want 0", Overrun_d); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_perr !== 1'b1 || out_data !== 8'h31 + 8'(i)) begin
        errors++; $display("FAIL perr_flag%0d: perr=%0b data=%h want 1/%h", i, out_perr, out_data, 8'h31 + 8'(i));
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 297; i++) send_byte(8'(i), 1'b1);
    out_ready = 1'b0;
    checks++; if (ErrCount !== 8'd255) begin errors++; $display("FAIL perr_sat: got %0d want 255", ErrCount); end
    checks++; if (ErrCount_d !== 8'd255) begin errors++; $display("FAIL perr_drop_sat: got %0d want 255", ErrCount_d); end
    ClrStatus = 1'b1; Dout = 8'hEE; parityErr = 1'b1; Receive = 1'b1;
    @(posedge clk); #1;
    ClrStatus = 1'b0;
    checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL perr_clear_wins: got %0d want 0", ErrCount); end
    Receive = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL perr_after_clear: got %0d want 0", ErrCount); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Dout = 8'h77; parityErr = 1'b1; Receive = 1'b1;
    @(posedge clk); #1;
    checks++; if (dbg_state !== ACK || Received !== 1'b1) begin
      errors++; $display("FAIL mid_ack: state=%0d received=%0b want %0d/1", dbg_state, Received, ACK);
    end
    #2;
    Reset_n = 1'b0;
    Receive = 1'b0;
    #1;
    checks++; if (Received !== 1'b0) begin errors++; $display("FAIL mid_received: got %0b want 0", Received); end
    checks++; if (dbg_state !== WAIT) begin errors++; $display("FAIL mid_state: got %0d want %0d", dbg_state, WAIT); end
    checks++; if (out_valid !== 1'b0 || Level !== 4'd0 || out_data !== 8'h00 || out_perr !== 1'b0) begin
      errors++; $display("FAIL mid_fifo: valid=%0b level=%0d data=%h perr=%0b want 0/0/00/0", out_valid, Level, out_data, out_perr);
    end
    checks++; if (ErrCount !== 8'd0 || Overrun !== 1'b0) begin
      errors++; $display("FAIL mid_status: errcount=%0d overrun=%0b want 0/0", ErrCount, Overrun);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h3C, 1'b0);
    checks++; if (Level !== 4'd1 || out_data !== 8'h3C || out_perr !== 1'b0) begin
      errors++; $display("FAIL mid_recover: level=%0d data=%h perr=%0b want 1/3c/0", Level, out_data, out_perr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_full_pop();
    test_perr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
Host-side controller for the UART receiver. It answers each receiver Receive/Received handshake and captures the byte and its parity flag into a small first-word-fall-through FIFO. It presents the bytes to a consumer over a valid/ready interface. It also keeps sticky overrun status and a saturating parity-error count for software or a top-level status register.

Parameters:
DEPTH, 8, FIFO entries; power of 2, range 2..64.
DROP_PERR, 0, when 1, bytes with a parity error are acknowledged and counted but not written.

Ports:
clk  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
Receive  input  1  receiver holds high while a byte is pending
Dout  input  8  receiver data, stable while Receive=1
parityErr  input  1  receiver parity error, stable while Receive=1
Received  output  1  acknowledge to receiver, one-cycle pulse
out_valid  output  1  FIFO head is valid
out_data  output  8  FIFO head byte
out_perr  output  1  parity flag of FIFO head
out_ready  input  1  consumer pops the head when out_valid & out_ready
Overrun  output  1  sticky: a byte was dropped because the FIFO was full
ErrCount  output  8  saturating count of parity-error bytes
Level  output  $clog2(DEPTH)+1  FIFO occupancy
ClrStatus  input  1  synchronous clear of Overrun and ErrCount

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (Reset_n).
- Reset values: state=WAIT, Received=0, out_valid=0, out_data=0, out_perr=0, Overrun=0, ErrCount=0, Level=0. FIFO pointers are cleared.
- Reset mid-handshake returns to WAIT. The receiver, on its own reset, returns to IDLE.
- Handshake FSM (Moore). Received=1 only in state ACK.
  - WAIT: if Receive=1, capture {parityErr,Dout} and go to ACK. Otherwise stay in WAIT.
  - ACK: unconditionally go to RELEASE. The receiver sees Received=1 for exactly one cycle and leaves DONE on that edge.
  - RELEASE: if Receive=0, go to WAIT. Otherwise stay in RELEASE. This guards against re-capturing the same byte.
- Capture timing: at the WAIT→ACK edge the entry is written, unless a drop rule below applies.
- Latency:
  - Receive rising before edge t gives write at edge t, Received high in cycle t..t+1, and out_valid high after edge t when the FIFO was empty.
  - Minimum of 3 cycles per byte. This is far below one UART frame, so the FSM never throttles the receiver.
- Drop on full: a write is dropped when Level==DEPTH and no pop happens in the same cycle. In that case set Overrun=1; the byte is still acknowledged.
- Simultaneous push and pop when full: both succeed and Level stays DEPTH.
- Simultaneous push and pop when empty: the push succeeds. The pop is ignored because out_valid=0.
- Parity errors:
  - Every captured byte with parityErr=1 increments ErrCount, whether it is written or dropped.
  - ErrCount saturates at 255.
  - If DROP_PERR=1, such bytes are not written; Overrun is not set for them.
- ClrStatus=1: Overrun<=0 and ErrCount<=0. Clear wins over a same-cycle increment or overrun event.
- FIFO:
  - out_data and out_perr reflect the head entry combinationally from storage.
  - out_valid = (Level!=0).
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - Level updates +1, -1 or 0 per cycle.
- Pop without valid has no effect.

Decomposition:
- Package uart_pkg: the FSM state enum {WAIT, ACK, RELEASE} (logic [1:0]), a packed struct rx_entry_t {perr, data[7:0]}, and the constant ERRCNT_MAX=255.
- Sub-module sync_fifo, parameterized by DEPTH with width 9. It provides push/pop/head/level and implements the full-with-pop rule.
- rx_ctrl contains the FSM, drop logic and status registers.

Test Plan:
- Byte 0xA5 with parityErr=0, Receive held until Received: Received is high for exactly 1 cycle. out_valid rises the cycle after capture, with out_data=0xA5, out_perr=0 and Level=1.
- Receive held high for 5 extra cycles after Received: exactly one entry is written, Level=1, and the FSM stays in RELEASE until Receive=0.
- DEPTH=8, push 9 bytes 0x00..0x08 with out_ready=0: Level=8 and Overrun=1. Popping returns 0x00..0x07; 0x08 is lost. ClrStatus then gives Overrun=0.
- Full FIFO with capture and out_ready=1 in the same cycle: Level stays 8, Overrun stays 0, and the new byte comes out last.
- 3 bytes with parityErr=1 and DROP_PERR=0: ErrCount=3 and out_perr=1 on each. The same stimulus with DROP_PERR=1 gives ErrCount=3, Level=0 and 3 Received pulses. 300 errors give ErrCount=255.
- Reset_n asserted low while in ACK, asynchronously mid-cycle: Received drops immediately and all outputs take their reset values. After release, the next byte is captured normally.
